// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: shares one LED between three requesters, each asking
// for a burst of N visible blinks. A round-robin arbiter picks a requester
// while idle, a prescaler turns clk into PRESCALE-cycle phases, and a
// sequencer FSM plays N x (ON, OFF) followed by one GAP phase.
//
// Ports:
//   clk     system clock
//   rst_n   synchronous active-low reset (aborts any sequence, no done pulse)
//   req     request level per requester (bit i = requester i)
//   blinks  blink count per requester, bits [i*BLINKS_W +: BLINKS_W]
//   led     registered LED drive, active high
//   gnt     one-hot grant, held for the whole sequence
//   done    one-cycle completion pulse for the granted requester
//   busy    high whenever the sequencer is not idle
//
// Optional feature: define LED_DIM_EN to dim the ON phase with a 4-bit
// free-running PWM (led = pwm < DIM during ON).
module led_blink_scheduler #(
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned BLINKS_W   = 3
`ifdef LED_DIM_EN
    ,
    parameter int unsigned DIM        = 4
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              req,
    input  logic [3*BLINKS_W-1:0]   blinks,
    output logic                    led,
    output logic [2:0]              gnt,
    output logic [2:0]              done,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [PRESCALE_W-1:0] pre, pre_n;
    logic [BLINKS_W-1:0]   cnt, cnt_n;
    logic [1:0]            last_grant, last_grant_n;
    logic [2:0]            gnt_n, done_n;
    logic                  led_n, busy_n;
    logic                  tick;
    logic [1:0]            pick;
    logic [BLINKS_W-1:0]   pick_cnt;
    logic                  led_on;

    // Round-robin pick: first requesting bit searching upward from last_grant+1.
    always_comb begin
        pick = 2'd0;
        case (last_grant)
            2'd0: begin
                if (req[1])      pick = 2'd1;
                else if (req[2]) pick = 2'd2;
                else             pick = 2'd0;
            end
            2'd1: begin
                if (req[2])      pick = 2'd2;
                else if (req[0]) pick = 2'd0;
                else             pick = 2'd1;
            end
            default: begin
                if (req[0])      pick = 2'd0;
                else if (req[1]) pick = 2'd1;
                else             pick = 2'd2;
            end
        endcase
        pick_cnt = blinks[int'(pick)*BLINKS_W +: BLINKS_W];
    end

    assign tick = (pre == PRESCALE_W'(PRESCALE - 1));

`ifdef LED_DIM_EN
    logic [3:0] pwm, pwm_n;

    // Free-running PWM; led is computed from the value the counter will hold
    // next so the registered led lines up with the registered pwm.
    assign pwm_n  = pwm + 4'd1;
    assign led_on = (32'(pwm_n) < DIM);

    always_ff @(posedge clk) begin
        if (!rst_n) pwm <= 4'd0;
        else        pwm <= pwm_n;
    end
`else
    assign led_on = 1'b1;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        pre_n        = pre;
        cnt_n        = cnt;
        last_grant_n = last_grant;
        gnt_n        = gnt;
        done_n       = 3'b000;
        busy_n       = busy;
        led_n        = 1'b0;

        if (state != IDLE) begin
            pre_n = tick ? '0 : pre + PRESCALE_W'(1);
        end

        case (state)
            IDLE: begin
                pre_n = '0;
                if (req != 3'b000) begin
                    gnt_n        = 3'b001 << pick;
                    last_grant_n = pick;
                    cnt_n        = pick_cnt;
                    busy_n       = 1'b1;
                    state_n      = (pick_cnt != '0) ? ON : GAP;
                end
            end
            ON: begin
                if (tick) begin
                    state_n = OFF;
                    cnt_n   = cnt - BLINKS_W'(1);
                end
            end
            OFF: begin
                if (tick) state_n = (cnt != '0) ? ON : GAP;
            end
            GAP: begin
                if (tick) begin
                    state_n = IDLE;
                    gnt_n   = 3'b000;
                    busy_n  = 1'b0;
                    done_n  = gnt;
                end
            end
            default: state_n = IDLE;
        endcase

        led_n = (state_n == ON) && led_on;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pre        <= '0;
            cnt        <= '0;
            last_grant <= 2'd2;
            gnt        <= 3'b000;
            done       <= 3'b000;
            busy       <= 1'b0;
            led        <= 1'b0;
        end else begin
            state      <= state_n;
            pre        <= pre_n;
            cnt        <= cnt_n;
            last_grant <= last_grant_n;
            gnt        <= gnt_n;
            done       <= done_n;
            busy       <= busy_n;
            led        <= led_n;
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench: a PRESCALE=4 instance for sequencing/arbitration/reset
// cases and a PRESCALE=32 instance for the ON-phase brightness case.
module tb_led_blink_scheduler;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [8:0] blinks;
    logic       led;
    logic [2:0] gnt;
    logic [2:0] done;
    logic       busy;

    logic [2:0] req_b;
    logic [8:0] blinks_b;
    logic       led_b;
    logic [2:0] gnt_b;
    logic [2:0] done_b;
    logic       busy_b;

    int checks = 0;
    int errors = 0;

    led_blink_scheduler #(.PRESCALE(4), .PRESCALE_W(16), .BLINKS_W(3)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .blinks (blinks),
        .led    (led),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy)
    );

    led_blink_scheduler #(.PRESCALE(32), .PRESCALE_W(16), .BLINKS_W(3)) u_dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_b),
        .blinks (blinks_b),
        .led    (led_b),
        .gnt    (gnt_b),
        .done   (done_b),
        .busy   (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] rr_exp [4];
        int         led_hi;
        int         gnt_hi;
        int         n;
        logic       led_prev;
        int         rises;

        rst_n    = 1'b0;
        req      = 3'b000;
        blinks   = 9'd0;
        req_b    = 3'b000;
        blinks_b = 9'd0;
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;

        // Reset state
        step();
        step();
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Basic sequence: requester 0, two blinks, PRESCALE=4
        req    = 3'b001;
        blinks = {3'd0, 3'd0, 3'd2};
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("basic_gnt", 32'(gnt), 32'b001);
            chk("basic_busy", 32'(busy), 32'd1);
            chk("basic_done", 32'(done), 32'd0);
`ifndef LED_DIM_EN
            chk("basic_led", 32'(led), ((((i - 1) / 4) % 2 == 0) && ((i - 1) / 4 < 4)) ? 32'd1 : 32'd0);
`else
            if (((i - 1) / 4) % 2 == 1 || ((i - 1) / 4) == 4) chk("basic_led_off", 32'(led), 32'd0);
`endif
        end
        step();
        chk("basic_end_gnt", 32'(gnt), 32'd0);
        chk("basic_end_done", 32'(done), 32'b001);
        chk("basic_end_busy", 32'(busy), 32'd0);
        chk("basic_end_led", 32'(led), 32'd0);
        req = 3'b000;
        step();
        chk("basic_done_once", 32'(done), 32'd0);

        // Round-robin from reset: all requesting, one blink each
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        req    = 3'b111;
        blinks = {3'd1, 3'd1, 3'd1};
        step();
        for (int g = 0; g < 4; g++) begin
            chk("rr_grant", 32'(gnt), 32'(rr_exp[g]));
            repeat (11) step();
            chk("rr_held", 32'(gnt), 32'(rr_exp[g]));
            step();
            chk("rr_drop", 32'(gnt), 32'd0);
            chk("rr_done", 32'(done), 32'(rr_exp[g]));
            if (g == 3) req = 3'b000;
            step();
        end
        chk("rr_idle", 32'(gnt), 32'd0);

        // Zero blinks: gap only
        req    = 3'b010;
        blinks = {3'd1, 3'd0, 3'd1};
        step();
        req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            chk("zero_gnt", 32'(gnt), 32'b010);
            chk("zero_led", 32'(led), 32'd0);
            step();
        end
        chk("zero_drop", 32'(gnt), 32'd0);
        chk("zero_done", 32'(done), 32'b010);
        step();
        chk("zero_done_once", 32'(done), 32'd0);

        // Mid-sequence req drop and blinks change are ignored
        req    = 3'b001;
        blinks = {3'd0, 3'd0, 3'd3};
        step();
        chk("mid_gnt", 32'(gnt), 32'b001);
        req    = 3'b000;
        blinks = {3'd0, 3'd0, 3'd7};
        led_hi   = 0;
        gnt_hi   = 0;
        rises    = 0;
        led_prev = 1'b0;
        n        = 0;
        while (done == 3'b000 && n < 100) begin
            if (gnt != 3'b000) gnt_hi++;
            if (led) led_hi++;
            if (led && !led_prev) rises++;
            led_prev = led;
            step();
            n++;
        end
        chk("mid_timeout", 32'(n < 100), 32'd1);
        chk("mid_done", 32'(done), 32'b001);
        chk("mid_gnt_len", 32'(gnt_hi), 32'd28);
`ifndef LED_DIM_EN
        chk("mid_led_hi", 32'(led_hi), 32'd12);
        chk("mid_blinks", 32'(rises), 32'd3);
`endif
        step();

        // Reset during OFF of a requester 2 sequence
        req    = 3'b100;
        blinks = {3'd2, 3'd0, 3'd0};
        step();
        chk("abort_gnt", 32'(gnt), 32'b100);
        repeat (5) step();
        chk("abort_in_off_led", 32'(led), 32'd0);
        rst_n = 1'b0;
        req   = 3'b101;
        step();
        chk("abort_led", 32'(led), 32'd0);
        chk("abort_gnt0", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("abort_regrant", 32'(gnt), 32'b001);
        chk("abort_nodone", 32'(done), 32'd0);
        req   = 3'b000;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // ON-phase brightness at PRESCALE=32, one blink
        req_b    = 3'b001;
        blinks_b = {3'd0, 3'd0, 3'd1};
        step();
        req_b  = 3'b000;
        led_hi = 0;
        gnt_hi = 0;
        n      = 0;
        while (done_b == 3'b000 && n < 200) begin
            if (gnt_b != 3'b000) gnt_hi++;
            if (led_b) led_hi++;
            step();
            n++;
        end
        chk("dim_timeout", 32'(n < 200), 32'd1);
        chk("dim_done", 32'(done_b), 32'b001);
        chk("dim_gnt_len", 32'(gnt_hi), 32'd96);
`ifdef LED_DIM_EN
        chk("dim_led_hi", 32'(led_hi), 32'd8);
`else
        chk("dim_led_hi", 32'(led_hi), 32'd32);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
